// File: rtl/if_prefetch_unit_if.sv
// Bus bundle between the instruction-fetch stage and its neighbours (debug unit, IF/ID boundary).
// The slave modport is the fetch unit; the master modport is whoever drives it.
interface if_prefetch_unit_if #(
  parameter int NB_REG  = 32,
  parameter int NB_ADDR = 9
);
  logic               i_clk_valid;
  logic               i_dunit_w_en;
  logic [NB_ADDR-1:0] i_dunit_addr;
  logic [NB_REG-1:0]  i_dunit_data;
  logic               i_redirect;
  logic [NB_REG-1:0]  i_redirect_pc;
  logic               i_stall;
  logic               o_valid;
  logic [NB_REG-1:0]  o_instruction;
  logic [NB_REG-1:0]  o_pc;
  logic [NB_REG-1:0]  o_pcplus4;
  logic               o_halt;
  logic               o_empty;

  modport master (
    output i_clk_valid, i_dunit_w_en, i_dunit_addr, i_dunit_data,
           i_redirect, i_redirect_pc, i_stall,
    input  o_valid, o_instruction, o_pc, o_pcplus4, o_halt, o_empty
  );

  modport slave (
    input  i_clk_valid, i_dunit_w_en, i_dunit_addr, i_dunit_data,
           i_redirect, i_redirect_pc, i_stall,
    output o_valid, o_instruction, o_pc, o_pcplus4, o_halt, o_empty
  );
endinterface

// File: rtl/if_prefetch_unit.sv
// MIPS instruction-fetch stage: PC, debug-loaded instruction memory and a prefetch queue
// feeding the IF/ID boundary with valid/stall, epoch-tagged redirect flush and HALT stop.
module if_prefetch_unit #(
  parameter int                NB_REG    = 32,
  parameter int                NB_ADDR   = 9,
  parameter int                PQ_DEPTH  = 4,
  parameter logic [NB_REG-1:0] RESET_PC  = '0,
  parameter logic [NB_REG-1:0] HALT_WORD = {NB_REG{1'b1}}
) (
  input  logic                i_clk,
  input  logic                i_reset,
  if_prefetch_unit_if.slave   bus
);
  localparam int              PTR_W     = $clog2(PQ_DEPTH);
  localparam int              CNT_W     = PTR_W + 1;
  localparam int              MEM_DEPTH = 2**NB_ADDR;
  localparam logic [CNT_W:0]  DEPTH_CNT = PQ_DEPTH[CNT_W:0];

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               fetch_en;

  logic [NB_REG-1:0]  pc_p0;
  logic [NB_REG-1:0]  mem [MEM_DEPTH];
  logic [NB_REG-1:0]  instr_p1, pc_p1;
  logic               vld_p1, epoch_p1, epoch;

  logic [NB_REG-1:0]  q_instr [PQ_DEPTH];
  logic [NB_REG-1:0]  q_pc    [PQ_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W:0]     occupancy;

  logic               step, redirect, resp_live, resp_halt;
  logic               issue, push, pop, q_empty, head_halt;
  logic [NB_ADDR-1:0] rd_idx;

  assign step      = bus.i_clk_valid;
  assign redirect  = bus.i_redirect;
  assign rd_idx    = pc_p0[NB_ADDR+1:2];
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, vld_p1};
  assign resp_live = vld_p1 && (epoch_p1 == epoch);
  assign resp_halt = resp_live && (instr_p1 == HALT_WORD);
  // The cycle a HALT word returns must not issue, so the PC stays just past it.
  assign issue     = fetch_en && !redirect && !resp_halt && (occupancy < DEPTH_CNT);
  assign push      = resp_live && !redirect;
  assign q_empty   = (count == '0);
  assign head_halt = !q_empty && (q_instr[rd_ptr] == HALT_WORD);
  assign pop       = !q_empty && !bus.i_stall && !head_halt && !redirect;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)   state_q <= S_RUN;
    else if (step) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect)                             state_d = S_RUN;
    else if (push && instr_p1 == HALT_WORD)   state_d = S_HALT;
  end

  always_comb begin
    fetch_en = (state_q == S_RUN);
  end

  // p0 -> p1: PC issue and in-flight tracking; queue pointers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc_p0    <= RESET_PC;
      vld_p1   <= 1'b0;
      epoch_p1 <= 1'b0;
      epoch    <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (step) begin
      if (redirect) begin
        pc_p0  <= bus.i_redirect_pc;
        vld_p1 <= 1'b0;
        epoch  <= ~epoch;
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (issue) pc_p0 <= pc_p0 + NB_REG'(4);
        vld_p1   <= issue;
        epoch_p1 <= epoch;
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // p1 -> queue: read-first memory and queue storage
  always_ff @(posedge i_clk) begin
    if (step) begin
      if (bus.i_dunit_w_en) mem[bus.i_dunit_addr] <= bus.i_dunit_data;
      if (issue) begin
        instr_p1 <= mem[rd_idx];
        pc_p1    <= pc_p0;
      end
      if (push) begin
        q_instr[wr_ptr] <= instr_p1;
        q_pc[wr_ptr]    <= pc_p1;
      end
    end
  end

  always_comb begin
    bus.o_valid       = !q_empty;
    bus.o_empty       = q_empty;
    bus.o_halt        = head_halt;
    bus.o_instruction = q_empty ? '0 : q_instr[rd_ptr];
    bus.o_pc          = q_empty ? '0 : q_pc[rd_ptr];
    bus.o_pcplus4     = q_empty ? '0 : q_pc[rd_ptr] + NB_REG'(4);
  end
endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit: streaming, stall, redirect, halt, step-enable and async reset.
module tb_if_prefetch_unit;
  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  if_prefetch_unit_if #(.NB_REG(32), .NB_ADDR(9)) bus ();

  if_prefetch_unit #(
    .NB_REG(32), .NB_ADDR(9), .PQ_DEPTH(4), .RESET_PC(32'h0), .HALT_WORD(32'hFFFF_FFFF)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [8:0] addr, input logic [31:0] data);
    bus.i_dunit_w_en = 1'b1;
    bus.i_dunit_addr = addr;
    bus.i_dunit_data = data;
    tick();
    bus.i_dunit_w_en = 1'b0;
  endtask

  task automatic restart();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", bus.o_valid); end
    n_checks++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %0b want 1", bus.o_empty); end
    n_checks++; if (bus.o_halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %0b want 0", bus.o_halt); end
    n_checks++; if (bus.o_instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", bus.o_instruction); end
    n_checks++; if (bus.o_pc !== 32'h0 || bus.o_pcplus4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h/%h want 0/0", bus.o_pc, bus.o_pcplus4); end
    for (int i = 0; i < 32; i++) write_word(i[8:0], 32'h1000_0000 + i);
  endtask

  task automatic test_stream();
    restart();
    tick();
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL stream_latency: got valid %0b after 1 edge want 0", bus.o_valid); end
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++;
      if (bus.o_valid !== 1'b1 || bus.o_instruction !== 32'h1000_0000 + k ||
          bus.o_pc !== 32'(4 * k) || bus.o_pcplus4 !== 32'(4 * k + 4)) begin
        n_fail++;
        $display("FAIL stream_word%0d: got v=%0b i=%h pc=%h pc4=%h want v=1 i=%h pc=%h pc4=%h",
                 k, bus.o_valid, bus.o_instruction, bus.o_pc, bus.o_pcplus4,
                 32'h1000_0000 + k, 32'(4 * k), 32'(4 * k + 4));
      end
    end
  endtask

  task automatic test_stall();
    restart();
    tick();
    tick();
    bus.i_stall = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++;
      if (bus.o_valid !== 1'b1 || bus.o_instruction !== 32'h1000_0000 || bus.o_pc !== 32'h0) begin
        n_fail++;
        $display("FAIL stall_frozen%0d: got v=%0b i=%h pc=%h want v=1 i=10000000 pc=0",
                 k, bus.o_valid, bus.o_instruction, bus.o_pc);
      end
    end
    bus.i_stall = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_checks++;
      if (bus.o_valid !== 1'b1 || bus.o_instruction !== 32'h1000_0000 + k || bus.o_pc !== 32'(4 * k)) begin
        n_fail++;
        $display("FAIL stall_resume%0d: got v=%0b i=%h pc=%h want v=1 i=%h pc=%h",
                 k, bus.o_valid, bus.o_instruction, bus.o_pc, 32'h1000_0000 + k, 32'(4 * k));
      end
    end
  endtask

  task automatic test_redirect();
    restart();
    bus.i_stall = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h40;
    tick();
    bus.i_redirect = 1'b0;
    bus.i_stall    = 1'b0;
    n_checks++; if (bus.o_valid !== 1'b0 || bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL redirect_flush: got v=%0b e=%0b want v=0 e=1", bus.o_valid, bus.o_empty); end
    tick();
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL redirect_early: got valid %0b one edge after redirect want 0", bus.o_valid); end
    tick();
    n_checks++;
    if (bus.o_valid !== 1'b1 || bus.o_instruction !== 32'h1000_0010 || bus.o_pc !== 32'h40 || bus.o_pcplus4 !== 32'h44) begin
      n_fail++;
      $display("FAIL redirect_target: got v=%0b i=%h pc=%h pc4=%h want v=1 i=10000010 pc=40 pc4=44",
               bus.o_valid, bus.o_instruction, bus.o_pc, bus.o_pcplus4);
    end
    tick();
    n_checks++;
    if (bus.o_instruction !== 32'h1000_0011 || bus.o_pc !== 32'h44) begin
      n_fail++;
      $display("FAIL redirect_next: got i=%h pc=%h want i=10000011 pc=44", bus.o_instruction, bus.o_pc);
    end
  endtask

  task automatic test_alias();
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h802;
    tick();
    bus.i_redirect = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus.o_valid !== 1'b1 || bus.o_instruction !== 32'h1000_0000 || bus.o_pc !== 32'h802 || bus.o_pcplus4 !== 32'h806) begin
      n_fail++;
      $display("FAIL alias_wrap: got v=%0b i=%h pc=%h pc4=%h want v=1 i=10000000 pc=802 pc4=806",
               bus.o_valid, bus.o_instruction, bus.o_pc, bus.o_pcplus4);
    end
    tick();
    n_checks++;
    if (bus.o_instruction !== 32'h1000_0001 || bus.o_pc !== 32'h806) begin
      n_fail++;
      $display("FAIL alias_next: got i=%h pc=%h want i=10000001 pc=806", bus.o_instruction, bus.o_pc);
    end
  endtask

  task automatic test_halt();
    rst = 1'b1;
    write_word(9'd3, 32'hFFFF_FFFF);
    rst = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (bus.o_instruction !== 32'h1000_0000 + k || bus.o_halt !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_pre%0d: got i=%h h=%0b want i=%h h=0", k, bus.o_instruction, bus.o_halt, 32'h1000_0000 + k);
      end
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (bus.o_halt !== 1'b1 || bus.o_valid !== 1'b1 || bus.o_pc !== 32'hC || bus.o_instruction !== 32'hFFFF_FFFF) begin
        n_fail++;
        $display("FAIL halt_hold%0d: got h=%0b v=%0b pc=%h i=%h want h=1 v=1 pc=c i=ffffffff",
                 k, bus.o_halt, bus.o_valid, bus.o_pc, bus.o_instruction);
      end
    end
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h0;
    tick();
    bus.i_redirect = 1'b0;
    n_checks++; if (bus.o_halt !== 1'b0 || bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL halt_clear: got h=%0b e=%0b want h=0 e=1", bus.o_halt, bus.o_empty); end
    tick();
    tick();
    n_checks++;
    if (bus.o_valid !== 1'b1 || bus.o_instruction !== 32'h1000_0000 || bus.o_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL halt_resume: got v=%0b i=%h pc=%h want v=1 i=10000000 pc=0", bus.o_valid, bus.o_instruction, bus.o_pc);
    end
    rst = 1'b1;
    write_word(9'd3, 32'h1000_0003);
    rst = 1'b0;
  endtask

  task automatic test_clk_valid();
    restart();
    for (int k = 0; k < 4; k++) tick();
    bus.i_clk_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (bus.o_valid !== 1'b1 || bus.o_instruction !== 32'h1000_0002 || bus.o_pc !== 32'h8 || bus.o_pcplus4 !== 32'hC) begin
        n_fail++;
        $display("FAIL freeze%0d: got v=%0b i=%h pc=%h pc4=%h want v=1 i=10000002 pc=8 pc4=c",
                 k, bus.o_valid, bus.o_instruction, bus.o_pc, bus.o_pcplus4);
      end
    end
    bus.i_clk_valid = 1'b1;
    for (int k = 3; k < 6; k++) begin
      tick();
      n_checks++;
      if (bus.o_instruction !== 32'h1000_0000 + k || bus.o_pc !== 32'(4 * k)) begin
        n_fail++;
        $display("FAIL unfreeze%0d: got i=%h pc=%h want i=%h pc=%h", k, bus.o_instruction, bus.o_pc, 32'h1000_0000 + k, 32'(4 * k));
      end
    end
  endtask

  task automatic test_async_reset();
    restart();
    for (int k = 0; k < 3; k++) tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.o_valid !== 1'b0 || bus.o_empty !== 1'b1 || bus.o_instruction !== 32'h0 ||
        bus.o_pc !== 32'h0 || bus.o_pcplus4 !== 32'h0 || bus.o_halt !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%0b e=%0b i=%h pc=%h pc4=%h h=%0b want 0/1/0/0/0/0",
               bus.o_valid, bus.o_empty, bus.o_instruction, bus.o_pc, bus.o_pcplus4, bus.o_halt);
    end
    tick();
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus.o_valid !== 1'b1 || bus.o_instruction !== 32'h1000_0000 || bus.o_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL async_restart: got v=%0b i=%h pc=%h want v=1 i=10000000 pc=0", bus.o_valid, bus.o_instruction, bus.o_pc);
    end
  endtask

  initial begin
    rst               = 1'b1;
    bus.i_clk_valid   = 1'b1;
    bus.i_dunit_w_en  = 1'b0;
    bus.i_dunit_addr  = '0;
    bus.i_dunit_data  = '0;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = '0;
    bus.i_stall       = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_alias();
    test_halt();
    test_clk_valid();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
